// File: rtl/aurora_tx_gearbox_66to20.sv
`default_nettype none
// ============================================================================
// Module   : aurora_tx_gearbox_66to20
// Brief    : Aurora 64b/66b TX gearbox, 66-bit blocks in, one 20-bit word out per clk
// Revision : 1.0 - initial release
// ============================================================================
module aurora_tx_gearbox_66to20 #(
  parameter int unsigned INIT_BLOCKS = 32,
  parameter logic [1:0]  IDLE_HDR    = 2'b10,
  parameter logic [63:0] IDLE_DATA   = 64'h7800000000000000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic [1:0]  blk_hdr,
  input  logic [63:0] blk_data,
  input  logic        blk_valid,
  output logic        blk_ready,
  output logic [19:0] data_out,
  output logic        data_valid,
  output logic        link_run
);

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;
  localparam logic [7:0] c_IC_LAST = 8'(INIT_BLOCKS - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [6:0]  r_cnt;
  logic [85:0] r_buf;
  logic [7:0]  r_ic;
  logic [19:0] r_data_out;
  logic        r_data_valid;

  logic        w_clear;
  logic        w_pop;
  logic        w_take;
  logic        w_use_user;
  logic [1:0]  w_src_hdr;
  logic [63:0] w_src_data;
  logic [65:0] w_blk_ser;
  logic [6:0]  w_base;
  logic [85:0] w_buf_shift;
  logic [85:0] w_buf_app;
  logic [85:0] w_buf_next;
  logic [6:0]  w_cnt_next;

  assign w_clear = !rst_b || !en;
  assign w_pop   = (r_cnt >= 7'd20);
  assign w_take  = (r_cnt < 7'd40);

  // ---------------- state machine: register ----------------
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= c_ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- state machine: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (r_state == c_ST_INIT && w_take && r_ic == c_IC_LAST) begin
      w_state_next = c_ST_RUN;
    end
  end

  // ---------------- state machine: outputs ----------------
  always_comb begin
    link_run   = (r_state == c_ST_RUN);
    blk_ready  = w_take && (r_state == c_ST_RUN) && rst_b && en;
    w_use_user = (r_state == c_ST_RUN) && blk_valid;
  end

  // Block source and reorder into serial order, element 0 leaves first.
  always_comb begin
    w_src_hdr  = w_use_user ? blk_hdr  : IDLE_HDR;
    w_src_data = w_use_user ? blk_data : IDLE_DATA;
    w_blk_ser[0] = w_src_hdr[1];
    w_blk_ser[1] = w_src_hdr[0];
    for (int i = 0; i < 64; i++) begin
      w_blk_ser[2+i] = w_src_data[63-i];
    end
  end

  // Pop happens before append; bits above the fill count are always zero, so OR appends.
  always_comb begin
    w_base      = w_pop ? (r_cnt - 7'd20) : r_cnt;
    w_buf_shift = w_pop ? {20'b0, r_buf[85:20]} : r_buf;
    w_buf_app   = w_take ? ({20'b0, w_blk_ser} << w_base) : '0;
    w_buf_next  = w_buf_shift | w_buf_app;
    w_cnt_next  = r_cnt - (w_pop ? 7'd20 : 7'd0) + (w_take ? 7'd66 : 7'd0);
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_buf        <= '0;
      r_cnt        <= '0;
      r_ic         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_buf        <= w_buf_next;
      r_cnt        <= w_cnt_next;
      r_data_valid <= w_pop;
      if (w_pop) begin
        r_data_out <= r_buf[19:0];
      end
      if (r_state == c_ST_INIT && w_take) begin
        r_ic <= r_ic + 8'd1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_gearbox_66to20.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aurora_tx_gearbox_66to20
// Brief    : directed bench for the 66-to-20 TX gearbox with a bit-queue reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_gearbox_66to20;

  localparam int          INIT_BLOCKS = 32;
  localparam logic [1:0]  IDLE_HDR    = 2'b10;
  localparam logic [63:0] IDLE_DATA   = 64'h7800000000000000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        en;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [19:0] data_out;
  logic        data_valid;
  logic        link_run;

  aurora_tx_gearbox_66to20 #(
    .INIT_BLOCKS (INIT_BLOCKS),
    .IDLE_HDR    (IDLE_HDR),
    .IDLE_DATA   (IDLE_DATA)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .en         (en),
    .blk_hdr    (blk_hdr),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .link_run   (link_run)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: serial bit queue, oldest bit at the front.
  bit          m_q[$];
  int          m_c;
  int          m_ic;
  logic        m_run;
  logic [19:0] m_dout;
  logic        m_dv;
  logic        exp_ready;

  logic        obs_ready;
  logic [19:0] obs_dout;
  logic        obs_dv;
  logic        obs_run;
  int          obs_cnt;

  task automatic model_edge();
    bit          pop;
    bit          take;
    logic [65:0] blk;
    if (!rst_b || !en) begin
      m_q.delete();
      m_c = 0; m_ic = 0; m_run = 1'b0; m_dout = '0; m_dv = 1'b0; exp_ready = 1'b0;
    end else begin
      pop  = (m_c >= 20);
      take = (m_c < 40);
      exp_ready = take && m_run;
      if (pop) begin
        for (int i = 0; i < 20; i++) m_dout[i] = m_q.pop_front();
        m_dv = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (take) begin
        blk = (m_run && blk_valid) ? {blk_hdr, blk_data} : {IDLE_HDR, IDLE_DATA};
        for (int i = 65; i >= 0; i--) m_q.push_back(blk[i]);
        if (!m_run) begin
          if (m_ic == INIT_BLOCKS - 1) m_run = 1'b1;
          m_ic++;
        end
      end
      m_c = m_c - (pop ? 20 : 0) + (take ? 66 : 0);
    end
  endtask

  // One clock: sample the pre-edge ready and fill count, advance the model, sample registered outputs.
  task automatic tick();
    #1;
    obs_ready = blk_ready;
    obs_cnt   = int'(dut.r_cnt);
    model_edge();
    @(posedge clk);
    #1;
    obs_dout = data_out;
    obs_dv   = data_valid;
    obs_run  = link_run;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; en = 1'b1; blk_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (obs_dout !== 20'h0) begin miscompares++; $display("FAIL reset_dout got %h want 00000", obs_dout); end
    vectors++;
    if (obs_dv !== 1'b0) begin miscompares++; $display("FAIL reset_dv got %b want 0", obs_dv); end
    vectors++;
    if (obs_run !== 1'b0) begin miscompares++; $display("FAIL reset_run got %b want 0", obs_run); end
    vectors++;
    if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", obs_ready); end
    vectors++;
    if (int'(dut.r_cnt) != 0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", int'(dut.r_cnt)); end
  endtask

  // Link-training run from release of reset/enable; replayed after mid-run reset and enable toggle.
  task automatic test_init_sequence(input string tag);
    int first_ready;
    int gaps;
    first_ready = -1;
    gaps = 0;
    rst_b = 1'b1; en = 1'b1;
    for (int k = 0; k < 110; k++) begin
      tick();
      vectors++;
      if ({obs_ready, obs_dv, obs_run, obs_dout} !== {exp_ready, m_dv, m_run, m_dout}) begin
        miscompares++;
        $display("FAIL %s_stream cyc %0d got rdy=%b dv=%b run=%b out=%h want rdy=%b dv=%b run=%b out=%h",
                 tag, k, obs_ready, obs_dv, obs_run, obs_dout, exp_ready, m_dv, m_run, m_dout);
      end
      if (obs_ready === 1'b1 && first_ready < 0) first_ready = k;
      if (k >= 1 && obs_dv !== 1'b1) gaps++;
      if (k == 0) begin
        vectors++;
        if (obs_dv !== 1'b0) begin miscompares++; $display("FAIL %s_dv_cyc0 got %b want 0", tag, obs_dv); end
      end
      if (k == 1) begin
        vectors++;
        if (obs_dout !== 20'h00079 || obs_dv !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_first_word got dv=%b out=%h want dv=1 out=00079", tag, obs_dv, obs_dout);
        end
      end
    end
    vectors++;
    if (first_ready != 105) begin
      miscompares++; $display("FAIL %s_first_ready got cycle %0d want cycle 105", tag, first_ready);
    end
    vectors++;
    if (gaps != 0) begin miscompares++; $display("FAIL %s_dv_gaps got %0d want 0", tag, gaps); end
  endtask

  task automatic test_full_rate();
    int   total;
    int   win;
    logic [63:0] n;
    total = 0; win = 0; n = 64'h0;
    blk_valid = 1'b1; blk_hdr = 2'b01; blk_data = 64'h0123_4567_0000_0000;
    for (int k = 0; k < 330; k++) begin
      tick();
      vectors++;
      if ({obs_ready, obs_dv, obs_dout} !== {exp_ready, m_dv, m_dout}) begin
        miscompares++;
        $display("FAIL full_stream cyc %0d got rdy=%b dv=%b out=%h want rdy=%b dv=%b out=%h",
                 k, obs_ready, obs_dv, obs_dout, exp_ready, m_dv, m_dout);
      end
      if (obs_ready === 1'b1) begin
        total++; win++; n = n + 64'd1;
        blk_data = 64'h0123_4567_0000_0000 + n;
      end
      if (k % 33 == 32) begin
        vectors++;
        if (win != 10) begin miscompares++; $display("FAIL full_window ending %0d got %0d want 10", k, win); end
        win = 0;
      end
    end
    vectors++;
    if (total != 100) begin miscompares++; $display("FAIL full_total got %0d want 100", total); end
  endtask

  task automatic test_idle_fill();
    int idle;
    int gaps;
    idle = 0; gaps = 0;
    blk_valid = 1'b0;
    for (int k = 0; k < 100 && idle < 5; k++) begin
      tick();
      vectors++;
      if ({obs_ready, obs_dv, obs_dout} !== {exp_ready, m_dv, m_dout}) begin
        miscompares++;
        $display("FAIL idle_stream cyc %0d got rdy=%b out=%h want rdy=%b out=%h", k, obs_ready, obs_dout, exp_ready, m_dout);
      end
      if (obs_dv !== 1'b1) gaps++;
      if (obs_ready === 1'b1) idle++;
    end
    vectors++;
    if (idle != 5) begin miscompares++; $display("FAIL idle_slots got %0d want 5", idle); end
    blk_valid = 1'b1; blk_hdr = 2'b01; blk_data = 64'hDEAD_BEEF_CAFE_F00D;
    for (int k = 0; k < 60; k++) begin
      tick();
      vectors++;
      if ({obs_ready, obs_dv, obs_dout} !== {exp_ready, m_dv, m_dout}) begin
        miscompares++;
        $display("FAIL idle_after cyc %0d got rdy=%b out=%h want rdy=%b out=%h", k, obs_ready, obs_dout, exp_ready, m_dout);
      end
      if (obs_dv !== 1'b1) gaps++;
      if (obs_ready === 1'b1) blk_data = blk_data + 64'd3;
    end
    vectors++;
    if (gaps != 0) begin miscompares++; $display("FAIL idle_dv_gaps got %0d want 0", gaps); end
  endtask

  task automatic test_reset_mid_run();
    blk_valid = 1'b1;
    for (int k = 0; k < 40 && m_c != 46; k++) begin
      tick();
      if (obs_ready === 1'b1) blk_data = blk_data + 64'd1;
    end
    rst_b = 1'b0;
    tick();
    vectors++;
    if (obs_cnt != 46) begin miscompares++; $display("FAIL midrst_cnt_before got %0d want 46", obs_cnt); end
    vectors++;
    if (int'(dut.r_cnt) != 0) begin miscompares++; $display("FAIL midrst_cnt got %0d want 0", int'(dut.r_cnt)); end
    vectors++;
    if ({obs_dv, obs_run, obs_dout} !== {1'b0, 1'b0, 20'h0}) begin
      miscompares++; $display("FAIL midrst_out got dv=%b run=%b out=%h want dv=0 run=0 out=00000", obs_dv, obs_run, obs_dout);
    end
    vectors++;
    if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready got %b want 0", obs_ready); end
    test_init_sequence("T4");
  endtask

  task automatic test_en_toggle();
    blk_valid = 1'b1;
    for (int k = 0; k < 10 && m_c >= 40; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL en_low_ready cyc %0d got %b want 0", k, obs_ready); end
      vectors++;
      if ({obs_dv, obs_run, obs_dout} !== {1'b0, 1'b0, 20'h0}) begin
        miscompares++; $display("FAIL en_low_out cyc %0d got dv=%b run=%b out=%h want 0/0/00000", k, obs_dv, obs_run, obs_dout);
      end
    end
    test_init_sequence("T5");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10000; k++) begin
      blk_valid = 1'($urandom_range(0, 1));
      blk_hdr   = 2'($urandom_range(0, 3));
      blk_data  = {$urandom, $urandom};
      tick();
      vectors++;
      if ({obs_ready, obs_dv, obs_dout} !== {exp_ready, m_dv, m_dout}) begin
        miscompares++;
        $display("FAIL rand_stream cyc %0d got rdy=%b dv=%b out=%h want rdy=%b dv=%b out=%h",
                 k, obs_ready, obs_dv, obs_dout, exp_ready, m_dv, m_dout);
      end
      vectors++;
      if (obs_cnt < 20 || obs_cnt > 85) begin
        miscompares++; $display("FAIL rand_cnt_range cyc %0d got %0d want 20..85", k, obs_cnt);
      end
    end
  endtask

  initial begin
    rst_b = 1'b0; en = 1'b1; blk_valid = 1'b0; blk_hdr = 2'b00; blk_data = 64'h0;
    test_reset();
    test_init_sequence("T1");
    test_full_rate();
    test_idle_fill();
    test_reset_mid_run();
    test_en_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
